// File: rtl/cdc_pkg.sv
// Shared CDC definitions: handshake state encoding, synchronizer depth bounds,
// and the transfer-counter width used when TOGGLE_HANDSHAKE_SENDER_STATS_EN is set.
package cdc_pkg;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } state_t;

    localparam int unsigned SYNC_STAGES_MIN = 2;
    localparam int unsigned SYNC_STAGES_MAX = 4;
    localparam int unsigned CNT_W           = 16;

endpackage

// File: rtl/sync_ff.sv
// Single-bit multi-flop synchronizer; synchronous active-high reset clears the chain.
module sync_ff
    import cdc_pkg::*;
#(
    parameter int unsigned STAGES = SYNC_STAGES_MIN
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Shift the asynchronous input through the flop chain
    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/toggle_handshake_sender.sv
// Source side of a two-phase (toggle) req/ack CDC handshake.
// A word is captured into hold_data and req is inverted; the word stays stable
// until the synchronized ack matches req, at which point done pulses once.
// Optional macro TOGGLE_HANDSHAKE_SENDER_STATS_EN adds a saturating xfer_count.
module toggle_handshake_sender
    import cdc_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] hold_data,
    output logic             req,
    input  logic             ack_async,
    output logic             done
`ifdef TOGGLE_HANDSHAKE_SENDER_STATS_EN
    ,
    output logic [CNT_W-1:0] xfer_count
`endif
);

    state_t           state_q;
    state_t           state_d;
    logic             ack_sync;
    logic             req_d;
    logic             done_d;
    logic             ready_d;
    logic [WIDTH-1:0] hold_d;

    // Bring the receive-domain ack toggle into clk before any use
    sync_ff #(
        .STAGES(SYNC_STAGES)
    ) u_ack_sync (
        .clk(clk),
        .rst(rst),
        .d  (ack_async),
        .q  (ack_sync)
    );

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            req       <= 1'b0;
            hold_data <= '0;
            done      <= 1'b0;
            in_ready  <= 1'b0;
        end else begin
            state_q   <= state_d;
            req       <= req_d;
            hold_data <= hold_d;
            done      <= done_d;
            in_ready  <= ready_d;
        end
    end

    // Next-state and next-output decode; ack changes in IDLE are ignored
    always_comb begin
        state_d = state_q;
        req_d   = req;
        hold_d  = hold_data;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    hold_d  = in_data;
                    req_d   = ~req;
                    state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (ack_sync == req) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
    end

`ifdef TOGGLE_HANDSHAKE_SENDER_STATS_EN
    // Count completed transfers, saturating at all-ones
    always_ff @(posedge clk) begin
        if (rst) begin
            xfer_count <= '0;
        end else if (done && (xfer_count != {CNT_W{1'b1}})) begin
            xfer_count <= xfer_count + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_toggle_handshake_sender.sv
// Directed bench for toggle_handshake_sender: a cycle table plus hand-written
// sequences for ack withholding, back-to-back transfers and mid-transfer reset.
module tb_toggle_handshake_sender;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [WIDTH-1:0] hold_data;
    logic             req;
    logic             ack_async;
    logic             done;
    logic             ack_drv;
    logic             imm_ack;
`ifdef TOGGLE_HANDSHAKE_SENDER_STATS_EN
    logic [15:0]      xfer_count;
`endif

    int errors = 0;
    int checks = 0;

    // Receiver model: either a directly driven ack or an immediate echo of req
    assign ack_async = imm_ack ? req : ack_drv;

    toggle_handshake_sender #(
        .WIDTH      (WIDTH),
        .SYNC_STAGES(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .hold_data (hold_data),
        .req       (req),
        .ack_async (ack_async),
        .done      (done)
`ifdef TOGGLE_HANDSHAKE_SENDER_STATS_EN
        ,
        .xfer_count(xfer_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       valid;
        logic [7:0] data;
        logic       ack;
        logic       e_ready;
        logic       e_req;
        logic [7:0] e_hold;
        logic       e_done;
    } vec_t;

    localparam int NV = 19;
    vec_t vec [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        imm_ack  = 1'b0;
        ack_drv  = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    logic [7:0] words [3];
    logic [7:0] seen [$];
    int         acc_cyc [3];
    int         idx;
    int         toggles;
    int         dones;
    logic       req_prev;
    logic       acc_pending;

    initial begin
        // rst, valid, data, ack | ready, req, hold, done
        vec[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
        vec[1]  = '{1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
        vec[2]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0};
        vec[3]  = '{1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0};
        vec[4]  = '{1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0};
        vec[5]  = '{1'b0, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b0};
        vec[6]  = '{1'b0, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b0};
        vec[7]  = '{1'b0, 1'b0, 8'h3C, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b1};
        vec[8]  = '{1'b0, 1'b0, 8'h3C, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b0};
        vec[9]  = '{1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0};
        vec[10] = '{1'b0, 1'b0, 8'h3C, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b0};
        vec[11] = '{1'b0, 1'b0, 8'h3C, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b0};
        vec[12] = '{1'b0, 1'b0, 8'h3C, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b0};
        vec[13] = '{1'b0, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, 8'h5A, 1'b0};
        vec[14] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h5A, 1'b0};
        vec[15] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b0};
        vec[16] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b0};
        vec[17] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h5A, 1'b1};
        vec[18] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h5A, 1'b0};

        imm_ack  = 1'b0;
        ack_drv  = 1'b0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;

        // Cycle table: reset, first capture, ack latency, ack glitch in IDLE, second transfer
        for (int i = 0; i < NV; i++) begin
            rst      = vec[i].rst;
            in_valid = vec[i].valid;
            in_data  = vec[i].data;
            ack_drv  = vec[i].ack;
            @(posedge clk);
            @(negedge clk);
            check($sformatf("vec%0d.in_ready", i), 32'(in_ready), 32'(vec[i].e_ready));
            check($sformatf("vec%0d.req", i), 32'(req), 32'(vec[i].e_req));
            check($sformatf("vec%0d.hold_data", i), 32'(hold_data), 32'(vec[i].e_hold));
            check($sformatf("vec%0d.done", i), 32'(done), 32'(vec[i].e_done));
        end

        // Ack withheld for 50 cycles while in_data keeps changing
        do_reset();
        in_valid = 1'b1;
        in_data  = 8'hA5;
        @(negedge clk);
        for (int c = 0; c < 50; c++) begin
            in_data = 8'($urandom);
            @(negedge clk);
            check($sformatf("hold%0d.hold_data", c), 32'(hold_data), 32'h0000_00A5);
            check($sformatf("hold%0d.req", c), 32'(req), 32'd1);
            check($sformatf("hold%0d.done", c), 32'(done), 32'd0);
            check($sformatf("hold%0d.in_ready", c), 32'(in_ready), 32'd0);
        end

        // Back-to-back words with an immediately echoing receiver
        do_reset();
        imm_ack     = 1'b1;
        words[0]    = 8'h01;
        words[1]    = 8'h02;
        words[2]    = 8'h03;
        idx         = 0;
        toggles     = 0;
        dones       = 0;
        req_prev    = req;
        acc_pending = 1'b0;
        in_valid    = 1'b1;
        in_data     = words[0];
        for (int c = 0; c < 60; c++) begin
            if (req !== req_prev) begin
                toggles++;
                seen.push_back(hold_data);
                req_prev = req;
            end
            if (done === 1'b1) dones++;
            if (acc_pending) begin
                acc_pending = 1'b0;
                idx++;
                if (idx < 3) in_data = words[idx];
                else in_valid = 1'b0;
            end
            if (in_valid && in_ready) begin
                acc_cyc[idx] = c;
                acc_pending  = 1'b1;
            end
            @(negedge clk);
        end
        check("b2b.accepted", 32'(idx), 32'd3);
        check("b2b.req_toggles", 32'(toggles), 32'd3);
        check("b2b.done_pulses", 32'(dones), 32'd3);
        check("b2b.words_seen", 32'(seen.size()), 32'd3);
        for (int k = 0; k < 3; k++) begin
            if (k < seen.size()) check($sformatf("b2b.word%0d", k), 32'(seen[k]), 32'(words[k]));
            else check($sformatf("b2b.word%0d", k), 32'hFFFF_FFFF, 32'(words[k]));
        end
        if (idx == 3) begin
            check("b2b.spacing01", 32'(acc_cyc[1] - acc_cyc[0]), 32'd4);
            check("b2b.spacing12", 32'(acc_cyc[2] - acc_cyc[1]), 32'd4);
        end

        // Reset asserted while waiting for ack aborts the transfer
        do_reset();
        in_valid = 1'b1;
        in_data  = 8'hC3;
        @(negedge clk);
        in_valid = 1'b0;
        check("abort.pre_req", 32'(req), 32'd1);
        check("abort.pre_hold", 32'(hold_data), 32'h0000_00C3);
        rst = 1'b1;
        @(negedge clk);
        check("abort.req", 32'(req), 32'd0);
        check("abort.hold_data", 32'(hold_data), 32'd0);
        check("abort.in_ready", 32'(in_ready), 32'd0);
        check("abort.done", 32'(done), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("abort.ready_after", 32'(in_ready), 32'd1);
        for (int c = 0; c < 4; c++) begin
            check($sformatf("abort.no_done%0d", c), 32'(done), 32'd0);
            @(negedge clk);
        end

`ifdef TOGGLE_HANDSHAKE_SENDER_STATS_EN
        // Counter preloaded near full saturates instead of wrapping
        do_reset();
        check("stats.reset", 32'(xfer_count), 32'd0);
        force dut.xfer_count = 16'hFFFE;
        @(negedge clk);
        release dut.xfer_count;
        imm_ack  = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h11;
        for (int c = 0; c < 12; c++) @(negedge clk);
        in_valid = 1'b0;
        for (int c = 0; c < 6; c++) @(negedge clk);
        check("stats.saturate", 32'(xfer_count), 32'h0000_FFFF);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
